// File: rtl/regfile_scoreboard_if.sv
// Register file / scoreboard bus: read ports, issue and writeback handshakes,
// flush and the trace/difftest snapshot outputs.
interface regfile_scoreboard_if #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int AW    = 5
);
    logic [AW-1:0]         rs1_addr;
    logic [XLEN-1:0]       rs1_data;
    logic                  rs1_busy;
    logic [AW-1:0]         rs2_addr;
    logic [XLEN-1:0]       rs2_data;
    logic                  rs2_busy;
    logic                  issue_valid;
    logic [AW-1:0]         issue_rd;
    logic                  issue_stall;
    logic                  wb_valid;
    logic [AW-1:0]         wb_rd;
    logic [XLEN-1:0]       wb_data;
    logic                  flush;
    logic [NREGS*XLEN-1:0] rf_flat;
    logic                  trace_valid;
    logic [63:0]           commit_cnt;
    logic                  sb_err;

    modport master (
        output rs1_addr, rs2_addr, issue_valid, issue_rd,
        output wb_valid, wb_rd, wb_data, flush,
        input  rs1_data, rs1_busy, rs2_data, rs2_busy, issue_stall,
        input  rf_flat, trace_valid, commit_cnt, sb_err
    );

    modport slave (
        input  rs1_addr, rs2_addr, issue_valid, issue_rd,
        input  wb_valid, wb_rd, wb_data, flush,
        output rs1_data, rs1_busy, rs2_data, rs2_busy, issue_stall,
        output rf_flat, trace_valid, commit_cnt, sb_err
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Integer register file with per-register pending-write counters, two bypassed
// read ports, one writeback port and a flattened snapshot for trace capture.
module regfile_scoreboard #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int CNTW  = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    regfile_scoreboard_if.slave  bus
);
    localparam logic [CNTW-1:0] CNT_MAX = '1;
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    logic [XLEN-1:0] r_regs [NREGS];
    logic [CNTW-1:0] r_cnt  [NREGS];
    logic            r_traceValid;
    logic [63:0]     r_commitCnt;
    logic            r_sbErr;

    logic            w_wbActive;
    logic            w_issueStall;
    logic            w_issueAccept;
    logic            w_underflow;
    logic [NREGS-1:0] w_inc;
    logic [NREGS-1:0] w_dec;
    logic            w_rs1Retire;
    logic            w_rs2Retire;

    assign w_wbActive    = bus.wb_valid && (bus.wb_rd != '0);
    assign w_issueStall  = bus.issue_valid && (bus.issue_rd != '0)
                           && (r_cnt[bus.issue_rd] == CNT_MAX);
    assign w_issueAccept = bus.issue_valid && (bus.issue_rd != '0) && !w_issueStall;
    // Flush suppresses the underflow check for a same-cycle writeback.
    assign w_underflow   = w_wbActive && !bus.flush && (r_cnt[bus.wb_rd] == '0);

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 1; i < NREGS; i++) begin
            w_inc[i] = w_issueAccept && (bus.issue_rd == AW'(i));
            w_dec[i] = w_wbActive && (bus.wb_rd == AW'(i));
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wbActive) begin
            r_regs[bus.wb_rd] <= bus.wb_data;
        end
    end

    // Issue and writeback to the same register cancel; a writeback with nothing pending holds at 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_cnt[0] <= '0;
            for (int i = 1; i < NREGS; i++) begin
                if (bus.flush) begin
                    r_cnt[i] <= '0;
                end else if (w_inc[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + CNT_ONE;
                end else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0)) begin
                    r_cnt[i] <= r_cnt[i] - CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_traceValid <= 1'b0;
            r_commitCnt  <= '0;
            r_sbErr      <= 1'b0;
        end else begin
            r_traceValid <= w_wbActive;
            if (bus.wb_valid) begin
                r_commitCnt <= r_commitCnt + 64'd1;
            end
            if (w_underflow) begin
                r_sbErr <= 1'b1;
            end
        end
    end

    assign w_rs1Retire = w_wbActive && (bus.wb_rd == bus.rs1_addr)
                         && (r_cnt[bus.rs1_addr] == CNT_ONE)
                         && !(w_issueAccept && (bus.issue_rd == bus.rs1_addr));
    assign w_rs2Retire = w_wbActive && (bus.wb_rd == bus.rs2_addr)
                         && (r_cnt[bus.rs2_addr] == CNT_ONE)
                         && !(w_issueAccept && (bus.issue_rd == bus.rs2_addr));

    assign bus.rs1_data = (bus.rs1_addr == '0) ? '0 :
                          (w_wbActive && (bus.wb_rd == bus.rs1_addr)) ? bus.wb_data :
                          r_regs[bus.rs1_addr];
    assign bus.rs2_data = (bus.rs2_addr == '0) ? '0 :
                          (w_wbActive && (bus.wb_rd == bus.rs2_addr)) ? bus.wb_data :
                          r_regs[bus.rs2_addr];

    assign bus.rs1_busy = (bus.rs1_addr != '0) && (r_cnt[bus.rs1_addr] != '0) && !w_rs1Retire;
    assign bus.rs2_busy = (bus.rs2_addr != '0) && (r_cnt[bus.rs2_addr] != '0) && !w_rs2Retire;

    assign bus.issue_stall = w_issueStall;
    assign bus.trace_valid = r_traceValid;
    assign bus.commit_cnt  = r_commitCnt;
    assign bus.sb_err      = r_sbErr;

    always_comb begin
        bus.rf_flat = '0;
        for (int i = 1; i < NREGS; i++) begin
            bus.rf_flat[i*XLEN +: XLEN] = r_regs[i];
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios then random traffic, all
// checked against an array-based architectural model of registers and pending counts.
module tb_regfile_scoreboard;
    localparam int XLEN   = 64;
    localparam int NREGS  = 32;
    localparam int CNTMAX = 3;

    logic clock;
    logic reset_n;

    regfile_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS), .AW(5)) bus ();

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .AW(5), .CNTW(2)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [63:0] mRegs [NREGS];
    int          mCnt  [NREGS];
    logic        mSbErr;
    logic        mTrace;
    logic [63:0] mCommit;

    int testsRun = 0;
    int testsFailed = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NREGS; i++) begin
            mRegs[i] = '0;
            mCnt[i]  = 0;
        end
        mSbErr  = 1'b0;
        mTrace  = 1'b0;
        mCommit = '0;
    endtask

    function automatic logic [63:0] modelRead(input int a, input bit wv, input int wrd,
                                             input logic [63:0] wd);
        if (a == 0) return '0;
        if (wv && wrd == a) return wd;
        return mRegs[a];
    endfunction

    function automatic logic modelBusy(input int a, input bit iv, input int ird,
                                       input bit wv, input int wrd, input bit stall);
        bit sameIssue;
        if (a == 0 || mCnt[a] == 0) return 1'b0;
        sameIssue = iv && ird == a && !stall;
        if (wv && wrd == a && mCnt[a] == 1 && !sameIssue) return 1'b0;
        return 1'b1;
    endfunction

    task automatic checkOutput();
        checkVal("trace_valid", {63'd0, bus.trace_valid}, {63'd0, mTrace});
        checkVal("commit_cnt", bus.commit_cnt, mCommit);
        checkVal("sb_err", {63'd0, bus.sb_err}, {63'd0, mSbErr});
        for (int i = 0; i < NREGS; i++) begin
            checkVal($sformatf("rf_flat_x%0d", i), bus.rf_flat[i*XLEN +: XLEN], mRegs[i]);
        end
    endtask

    // One clock cycle: drive, check combinational outputs, advance, check state.
    task automatic applyStimulus(input bit iv, input int ird, input bit wv, input int wrd,
                                 input logic [63:0] wd, input bit fl, input int a1, input int a2);
        bit stall;
        bus.issue_valid = iv;
        bus.issue_rd    = 5'(ird);
        bus.wb_valid    = wv;
        bus.wb_rd       = 5'(wrd);
        bus.wb_data     = wd;
        bus.flush       = fl;
        bus.rs1_addr    = 5'(a1);
        bus.rs2_addr    = 5'(a2);
        #3;
        stall = iv && ird != 0 && mCnt[ird] == CNTMAX;
        checkVal("issue_stall", {63'd0, bus.issue_stall}, {63'd0, stall});
        checkVal("rs1_data", bus.rs1_data, modelRead(a1, wv, wrd, wd));
        checkVal("rs2_data", bus.rs2_data, modelRead(a2, wv, wrd, wd));
        checkVal("rs1_busy", {63'd0, bus.rs1_busy}, {63'd0, modelBusy(a1, iv, ird, wv, wrd, stall)});
        checkVal("rs2_busy", {63'd0, bus.rs2_busy}, {63'd0, modelBusy(a2, iv, ird, wv, wrd, stall)});
        @(posedge clock);
        if (wv) mCommit = mCommit + 64'd1;
        mTrace = wv && wrd != 0;
        if (wv && wrd != 0) mRegs[wrd] = wd;
        if (fl) begin
            for (int i = 0; i < NREGS; i++) mCnt[i] = 0;
        end else begin
            if (wv && wrd != 0 && mCnt[wrd] == 0) mSbErr = 1'b1;
            if (iv && ird != 0 && !stall) mCnt[ird] = mCnt[ird] + 1;
            if (wv && wrd != 0 && mCnt[wrd] > 0) mCnt[wrd] = mCnt[wrd] - 1;
        end
        #1;
        checkOutput();
    endtask

    initial begin
        reset_n = 1'b0;
        bus.issue_valid = 1'b0; bus.issue_rd = '0;
        bus.wb_valid = 1'b0;    bus.wb_rd = '0; bus.wb_data = '0;
        bus.flush = 1'b0;       bus.rs1_addr = '0; bus.rs2_addr = '0;
        modelReset();
        #12;
        checkOutput();
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        for (int i = 0; i < NREGS; i += 2) applyStimulus(0, 0, 0, 0, '0, 0, i, i + 1);

        applyStimulus(1, 5, 0, 0, '0, 0, 0, 0);
        applyStimulus(0, 0, 1, 5, 64'hDEAD_BEEF, 0, 5, 0);
        checkVal("x5_after_wb", bus.rf_flat[5*XLEN +: XLEN], 64'hDEAD_BEEF);
        checkVal("trace_after_x5", {63'd0, bus.trace_valid}, 64'd1);

        applyStimulus(0, 0, 1, 0, 64'h1, 0, 0, 0);
        checkVal("trace_after_x0", {63'd0, bus.trace_valid}, 64'd0);
        checkVal("commit_after_x0", bus.commit_cnt, 64'd2);

        for (int i = 0; i < 4; i++) applyStimulus(1, 7, 0, 0, '0, 0, 7, 0);
        applyStimulus(0, 0, 1, 7, 64'h71, 0, 7, 0);
        applyStimulus(0, 0, 1, 7, 64'h72, 0, 7, 0);
        applyStimulus(0, 0, 0, 0, '0, 0, 7, 0);
        applyStimulus(0, 0, 1, 7, 64'h73, 0, 7, 7);
        applyStimulus(0, 0, 0, 0, '0, 0, 7, 0);

        applyStimulus(0, 0, 1, 9, 64'h99, 0, 9, 0);
        checkVal("sb_err_set", {63'd0, bus.sb_err}, 64'd1);
        applyStimulus(1, 3, 0, 0, '0, 0, 3, 0);
        applyStimulus(1, 3, 0, 0, '0, 1, 3, 0);
        applyStimulus(0, 0, 0, 0, '0, 0, 3, 9);
        checkVal("sb_err_sticky", {63'd0, bus.sb_err}, 64'd1);

        applyStimulus(1, 4, 0, 0, '0, 0, 4, 0);
        applyStimulus(1, 4, 1, 4, 64'h44, 0, 4, 0);
        #2;
        reset_n = 1'b0;
        #1;
        modelReset();
        checkOutput();
        bus.rs1_addr = 5'd4;
        bus.wb_valid = 1'b0;
        bus.issue_valid = 1'b0;
        #1;
        checkVal("x4_busy_after_reset", {63'd0, bus.rs1_busy}, 64'd0);
        checkVal("x4_data_after_reset", bus.rs1_data, 64'd0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        for (int n = 0; n < 400; n++) begin
            int ird;
            int wrd;
            ird = (($urandom % 4) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 5));
            wrd = (($urandom % 4) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 5));
            applyStimulus(($urandom % 2) == 1, ird, ($urandom % 2) == 1, wrd,
                          {$urandom, $urandom}, ($urandom % 32) == 0,
                          (($urandom % 2) == 1) ? wrd : int'($urandom_range(0, 31)),
                          (($urandom % 2) == 1) ? ird : int'($urandom_range(0, 7)));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
